// File: rtl/mess_pack_fifo.sv
// rtl/mess_pack_fifo.sv - nibble-to-word packer in front of a word FIFO
//
// Nibbles arrive LSB-first and are packed into a DATA_WIDTH-bit partial word.
// Each completed word is committed to a 2^ADDR_WIDTH-entry FIFO. Words are
// read out with a one-cycle registered latency.
//
// Optional feature macro: MESS_PACK_FLUSH_EN
//   Defined   : flush commits a partial word, zero-padded in its upper bits.
//   Undefined : flush is ignored, so only complete words are committed.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   din      in   message nibble (MESS_WIDTH)
//   wr_req   in   nibble write request, dropped while full
//   full     out  FIFO holds 2^ADDR_WIDTH complete words
//   flush    in   commit the partial word (MESS_PACK_FLUSH_EN only)
//   rd_req   in   word read request, ignored while empty
//   dout     out  packed word read out (DATA_WIDTH)
//   dout_vld out  dout was loaded by a read on the previous edge
//   empty    out  no complete word stored
//   nib_cnt  out  nibbles held in the partial word
module mess_pack_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int MESS_WIDTH = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [MESS_WIDTH-1:0]                          din,
    input  logic                                           wr_req,
    output logic                                           full,
    input  logic                                           flush,
    input  logic                                           rd_req,
    output logic [DATA_WIDTH-1:0]                          dout,
    output logic                                           dout_vld,
    output logic                                           empty,
    output logic [$clog2(DATA_WIDTH/MESS_WIDTH):0]         nib_cnt
);

    localparam int N     = DATA_WIDTH / MESS_WIDTH;
    localparam int CW    = $clog2(N) + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0]         CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH:0]   PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_partial;
    logic [CW-1:0]         r_nib_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_vld;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_last;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_merged;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                      (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    assign w_wr_acc = wr_req && !w_full;
    assign w_rd_acc = rd_req && !w_empty;
    assign w_last   = w_wr_acc && (r_nib_cnt == CNT_LAST);

`ifdef MESS_PACK_FLUSH_EN
    // An accepted nibble on the flush cycle is merged first, so a flush with
    // an otherwise empty partial word still commits that single nibble.
    assign w_commit = w_last ||
                      (flush && !w_full && ((r_nib_cnt != '0) || w_wr_acc));
`else
    logic w_flush_unused;
    assign w_flush_unused = flush;
    assign w_commit       = w_last;
`endif

    // Partial word with the incoming nibble dropped into its slot; on the
    // last nibble this is exactly the completed word.
    always_comb begin
        w_merged = r_partial;
        if (w_wr_acc) begin
            for (int k = 0; k < N; k++) begin
                if (r_nib_cnt == CW'(k)) begin
                    w_merged[k*MESS_WIDTH +: MESS_WIDTH] = din;
                end
            end
        end
    end

    // Write side: packing register and write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_partial <= '0;
            r_nib_cnt <= '0;
        end else if (w_commit) begin
            r_wr_ptr  <= r_wr_ptr + PTR_ONE;
            r_partial <= '0;
            r_nib_cnt <= '0;
        end else if (w_wr_acc) begin
            r_partial <= w_merged;
            r_nib_cnt <= r_nib_cnt + CNT_ONE;
        end
    end

    // Storage array is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_merged;
        end
    end

    // Read side: registered output, valid strobe for one cycle per read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign nib_cnt  = r_nib_cnt;

endmodule

// File: tb/tb_mess_pack_fifo.sv
// tb/tb_mess_pack_fifo.sv - randomized self-checking bench for mess_pack_fifo
module tb_mess_pack_fifo;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int MW    = 4;
    localparam int N     = DW / MW;
    localparam int DEPTH = 1 << AW;
`ifdef MESS_PACK_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] din;
    logic          wr_req;
    logic          flush;
    logic          rd_req;
    logic          full;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          empty;
    logic [3:0]    nib_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: stored words and the nibbles of the pending word.
    logic [DW-1:0] m_q[$];
    logic [MW-1:0] m_nibs[$];
    logic [DW-1:0] m_dout;
    logic          m_vld;

    mess_pack_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MESS_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_req(wr_req), .full(full),
        .flush(flush), .rd_req(rd_req), .dout(dout), .dout_vld(dout_vld),
        .empty(empty), .nib_cnt(nib_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_nibs.delete();
        m_dout = '0;
        m_vld  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, wait past the edge.
    task automatic step(input logic wr, input logic [MW-1:0] d,
                        input logic rd, input logic fl);
        bit            mfull, mempty, acc, rdok, commit;
        logic [DW-1:0] w;
        wr_req = wr; din = d; rd_req = rd; flush = fl;
        mfull  = (m_q.size() == DEPTH);
        mempty = (m_q.size() == 0);
        acc    = wr && !mfull;
        rdok   = rd && !mempty;
        if (acc) m_nibs.push_back(d);
        commit = (m_nibs.size() == N) ||
                 (FLUSH_EN && fl && !mfull && m_nibs.size() > 0);
        m_vld = rdok;
        if (rdok) m_dout = m_q.pop_front();
        if (commit) begin
            w = '0;
            foreach (m_nibs[k]) w = w | (DW'(m_nibs[k]) << (MW * k));
            m_q.push_back(w);
            m_nibs.delete();
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        if (dout !== '0)       begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
        if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", dout_vld); end
        if (nib_cnt !== 4'd0)  begin bad++; $display("FAIL reset_nib_cnt got=%0d want=0", nib_cnt); end
    endtask

    task automatic test_basic_pack();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, MW'(i), 1'b0, 1'b0);
            total++;
            if (nib_cnt !== 4'(m_nibs.size()))
                begin bad++; $display("FAIL basic_nib_cnt got=%0d want=%0d", nib_cnt, m_nibs.size()); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total += 3;
        if (dout !== 32'h87654321) begin bad++; $display("FAIL basic_dout got=%h want=87654321", dout); end
        if (dout_vld !== 1'b1)     begin bad++; $display("FAIL basic_vld got=%b want=1", dout_vld); end
        if (empty !== 1'b1)        begin bad++; $display("FAIL basic_empty got=%b want=1", empty); end
        step(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (dout_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_drop got=%b want=0", dout_vld); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < N * DEPTH; i++) step(1'b1, MW'($urandom), 1'b0, 1'b0);
        total += 2;
        if (full !== 1'b1)  begin bad++; $display("FAIL fill_full got=%b want=1", full); end
        if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b want=0", empty); end
        step(1'b1, 4'hF, 1'b0, 1'b0);
        total += 2;
        if (nib_cnt !== 4'd0) begin bad++; $display("FAIL fill_drop_nib got=%0d want=0", nib_cnt); end
        if (full !== 1'b1)    begin bad++; $display("FAIL fill_drop_full got=%b want=1", full); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total += 2;
            if (dout_vld !== 1'b1) begin bad++; $display("FAIL drain_vld[%0d] got=%b want=1", i, dout_vld); end
            if (dout !== m_dout)   begin bad++; $display("FAIL drain_dout[%0d] got=%h want=%h", i, dout, m_dout); end
        end
        total += 2;
        if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        if (full !== 1'b0)  begin bad++; $display("FAIL drain_full got=%b want=0", full); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N * 4 + N - 1; i++) step(1'b1, MW'($urandom), 1'b0, 1'b0);
        step(1'b1, MW'($urandom), 1'b1, 1'b0);
        total += 3;
        if (dout !== m_dout)  begin bad++; $display("FAIL b2b_dout got=%h want=%h", dout, m_dout); end
        if (nib_cnt !== 4'd0) begin bad++; $display("FAIL b2b_nib got=%0d want=0", nib_cnt); end
        if (m_q.size() != 4 || full !== 1'b0)
            begin bad++; $display("FAIL b2b_occupancy got_full=%b model=%0d want=4", full, m_q.size()); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total += 2;
            if (dout !== m_dout) begin bad++; $display("FAIL b2b_drain[%0d] got=%h want=%h", i, dout, m_dout); end
            if (empty !== (i == 3)) begin bad++; $display("FAIL b2b_empty[%0d] got=%b want=%b", i, empty, i == 3); end
        end
    endtask

    task automatic test_reset_mid_pack();
        for (int i = 0; i < 5; i++) step(1'b1, MW'(i + 3), 1'b0, 1'b0);
        #4;
        rst = 1'b0;
        model_reset();
        #1;
        total += 2;
        if (nib_cnt !== 4'd0) begin bad++; $display("FAIL midrst_nib got=%0d want=0", nib_cnt); end
        if (empty !== 1'b1)   begin bad++; $display("FAIL midrst_empty got=%b want=1", empty); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (dout !== 32'hAAAAAAAA) begin bad++; $display("FAIL midrst_dout got=%h want=aaaaaaaa", dout); end
    endtask

    task automatic test_flush();
        step(1'b0, '0, 1'b0, 1'b1);
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL flush_idle_empty got=%b want=1", empty); end
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
`ifdef MESS_PACK_FLUSH_EN
        total += 2;
        if (empty !== 1'b0)   begin bad++; $display("FAIL flush_empty got=%b want=0", empty); end
        if (nib_cnt !== 4'd0) begin bad++; $display("FAIL flush_nib got=%0d want=0", nib_cnt); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (dout !== 32'h00000CBA) begin bad++; $display("FAIL flush_dout got=%h want=00000cba", dout); end
`else
        total += 2;
        if (empty !== 1'b1)   begin bad++; $display("FAIL flush_empty got=%b want=1", empty); end
        if (nib_cnt !== 4'd3) begin bad++; $display("FAIL flush_nib got=%0d want=3", nib_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step(($urandom % 4) != 0, MW'($urandom), ($urandom % 3) == 0,
                 ($urandom % 16) == 0);
            total += 4;
            if (dout_vld !== m_vld) begin bad++; $display("FAIL rnd_vld[%0d] got=%b want=%b", c, dout_vld, m_vld); end
            if (dout !== m_dout)    begin bad++; $display("FAIL rnd_dout[%0d] got=%h want=%h", c, dout, m_dout); end
            if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH))
                begin bad++; $display("FAIL rnd_flags[%0d] got=%b%b model_words=%0d", c, empty, full, m_q.size()); end
            if (nib_cnt !== 4'(m_nibs.size()))
                begin bad++; $display("FAIL rnd_nib[%0d] got=%0d want=%0d", c, nib_cnt, m_nibs.size()); end
        end
    endtask

    initial begin
        rst = 1'b0; din = '0; wr_req = 1'b0; flush = 1'b0; rd_req = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_basic_pack();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid_pack();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
